// File: rtl/lane_pattern_sched.sv
// -----------------------------------------------------------------------------
// lane_pattern_sched
//
// Several vehicle-sensor lanes share one BCCCB (0-1-1-1-0) Mealy detector.
// Every lane has a one-deep sample buffer and its own saved 3-bit detector
// state. A round-robin arbiter picks one full buffer per cycle. The shared
// next-state logic then advances that lane's state. Overlap is allowed: the
// closing Bike also opens the next pattern. Each lane has a saturating
// detection counter, and the host reads it through cnt_sel / cnt_val.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous reset, active low
//   en          scheduler enable (no grants while low)
//   soft_clr    synchronous clear of buffers, contexts, counters, arbiter
//   lane_valid  per-lane sample valid
//   lane_data   per-lane sample (0 = Bike, 1 = Car)
//   lane_ready  per-lane buffer can accept a sample this cycle
//   det_valid   registered one-cycle detection pulse
//   det_lane    lane that completed the pattern (holds between pulses)
//   cnt_sel     counter read select
//   cnt_val     detection counter of lane cnt_sel (combinational read)
// -----------------------------------------------------------------------------
module lane_pattern_sched #(
   parameter int LANES = 4,
   parameter int CNT_W = 8,
   localparam int LW = $clog2(LANES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             soft_clr,
   input  logic [LANES-1:0] lane_valid,
   input  logic [LANES-1:0] lane_data,
   output logic [LANES-1:0] lane_ready,
   output logic             det_valid,
   output logic [LW-1:0]    det_lane,
   input  logic [LW-1:0]    cnt_sel,
   output logic [CNT_W-1:0] cnt_val
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_B    = 3'd1,
      ST_BC   = 3'd2,
      ST_BCC  = 3'd3,
      ST_BCCC = 3'd4
   } ctx_state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [LW-1:0]    LAST_IDX = LW'(LANES - 1);

   // Per-lane context, gathered from the per-lane generate blocks
   logic [LANES-1:0] buf_full;
   logic [LANES-1:0] buf_data;
   logic [2:0]       state_vec [LANES];
   logic [CNT_W-1:0] cnt_vec   [LANES];

   // Arbiter
   logic             arb_en;
   logic [LW-1:0]    last_grant_reg;
   logic             grant_any;
   logic [LW-1:0]    grant_idx;
   logic [LANES-1:0] grant;
   int               scan_idx;

   // Shared detector datapath
   logic [2:0]       sel_state;
   logic             sel_data;
   ctx_state_t       next_state;
   logic             detect;

   // Registered outputs
   logic             det_valid_reg;
   logic [LW-1:0]    det_lane_reg;

   assign arb_en = en && !soft_clr;

   // Round-robin search. The scan starts one past the last granted lane and
   // wraps. It looks only at registered buf_full, so a sample is eligible in
   // the cycle after it lands in the buffer.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      scan_idx  = 0;
      for (int k = 1; k <= LANES; k++) begin
         scan_idx = (int'(last_grant_reg) + k) % LANES;
         if (!grant_any && buf_full[LW'(scan_idx)]) begin
            grant_any = 1'b1;
            grant_idx = LW'(scan_idx);
         end
      end
      if (!arb_en) begin
         grant_any = 1'b0;
      end
   end

   // Mux in the granted lane's context for the single shared FSM
   assign sel_state = state_vec[grant_idx];
   assign sel_data  = buf_data[grant_idx];

   always_comb begin
      next_state = ST_IDLE;
      detect     = 1'b0;
      case (sel_state)
         ST_IDLE: next_state = sel_data ? ST_IDLE : ST_B;
         ST_B:    next_state = sel_data ? ST_BC   : ST_B;
         ST_BC:   next_state = sel_data ? ST_BCC  : ST_B;
         ST_BCC:  next_state = sel_data ? ST_BCCC : ST_B;
         ST_BCCC: begin
            // The closing Bike also starts the next pattern, so go to B
            next_state = sel_data ? ST_IDLE : ST_B;
            detect     = !sel_data;
         end
         default: next_state = ST_IDLE; // 5..7: recover silently
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic             full_reg;
         logic             data_reg;
         logic [2:0]       st_reg;
         logic [CNT_W-1:0] cnt_reg;
         logic             xfer;

         assign grant[gi]      = grant_any && (grant_idx == LW'(gi));
         // A granted buffer is drained this edge, so it can take a new
         // sample at the same time.
         assign lane_ready[gi] = !soft_clr && (!full_reg || grant[gi]);
         assign xfer           = lane_valid[gi] && lane_ready[gi];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               full_reg <= 1'b0;
               data_reg <= 1'b0;
               st_reg   <= ST_IDLE;
               cnt_reg  <= '0;
            end else if (soft_clr) begin
               full_reg <= 1'b0;
               data_reg <= 1'b0;
               st_reg   <= ST_IDLE;
               cnt_reg  <= '0;
            end else begin
               if (xfer) begin
                  full_reg <= 1'b1;
                  data_reg <= lane_data[gi];
               end else if (grant[gi]) begin
                  full_reg <= 1'b0;
               end
               if (grant[gi]) begin
                  st_reg <= next_state;
                  if (detect && (cnt_reg != CNT_MAX)) begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end
            end
         end

         assign buf_full[gi]  = full_reg;
         assign buf_data[gi]  = data_reg;
         assign state_vec[gi] = st_reg;
         assign cnt_vec[gi]   = cnt_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_reg <= LAST_IDX;
         det_valid_reg  <= 1'b0;
         det_lane_reg   <= '0;
      end else if (soft_clr) begin
         last_grant_reg <= LAST_IDX;
         det_valid_reg  <= 1'b0;
      end else begin
         det_valid_reg <= grant_any && detect;
         if (grant_any) begin
            last_grant_reg <= grant_idx;
         end
         if (grant_any && detect) begin
            det_lane_reg <= grant_idx;
         end
      end
   end

   assign det_valid = det_valid_reg;
   assign det_lane  = det_lane_reg;

   // Compare-and-select read, so a select value past LANES-1 reads zero
   always_comb begin
      cnt_val = '0;
      for (int k = 0; k < LANES; k++) begin
         if (cnt_sel == LW'(k)) begin
            cnt_val = cnt_vec[k];
         end
      end
   end

endmodule

// File: tb/tb_lane_pattern_sched.sv
// -----------------------------------------------------------------------------
// tb_lane_pattern_sched
//
// Directed bench for lane_pattern_sched with 4 lanes and 2-bit counters.
// Lane streams are held in seq_a/len_a. Bit k of seq_a[i] is the k-th sample
// of lane i. run_streams drives the streams with a valid/ready handshake.
// A negedge monitor logs every detection pulse with its lane and edge count.
// -----------------------------------------------------------------------------
module tb_lane_pattern_sched;

   localparam int LANES = 4;
   localparam int CNT_W = 2;
   localparam int LW    = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             soft_clr;
   logic [LANES-1:0] lane_valid;
   logic [LANES-1:0] lane_data;
   logic [LANES-1:0] lane_ready;
   logic             det_valid;
   logic [LW-1:0]    det_lane;
   logic [LW-1:0]    cnt_sel;
   logic [CNT_W-1:0] cnt_val;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   int          det_lane_q [$];
   int          det_cyc_q  [$];
   int          ready_log  [$];
   int          last_xfer_cyc [LANES];
   logic [31:0] seq_a [LANES];
   int          len_a [LANES];

   lane_pattern_sched #(
      .LANES (LANES),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .soft_clr   (soft_clr),
      .lane_valid (lane_valid),
      .lane_data  (lane_data),
      .lane_ready (lane_ready),
      .det_valid  (det_valid),
      .det_lane   (det_lane),
      .cnt_sel    (cnt_sel),
      .cnt_val    (cnt_val)
   );

   always #5 clk = ~clk;

   // Edge counter: at posedge+1 it holds the number of edges seen so far
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (det_valid) begin
         det_lane_q.push_back(int'(det_lane));
         det_cyc_q.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) begin
         n_pass++;
         $display("ok   %s got=%0d", tag, got);
      end else begin
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int q_lane(input int k);
      return (k < det_lane_q.size()) ? det_lane_q[k] : -1;
   endfunction

   function automatic int q_cyc(input int k);
      return (k < det_cyc_q.size()) ? det_cyc_q[k] : -1000;
   endfunction

   function automatic int log_at(input int k);
      return (k < ready_log.size()) ? ready_log[k] : -1;
   endfunction

   task automatic clear_seq();
      for (int i = 0; i < LANES; i++) begin
         seq_a[i] = 32'h0;
         len_a[i] = 0;
      end
   endtask

   task automatic clear_log();
      det_lane_q.delete();
      det_cyc_q.delete();
   endtask

   task automatic read_cnt(input string tag, input int lane, input int exp);
      cnt_sel = LW'(lane);
      #1;
      check(tag, int'(cnt_val), exp);
   endtask

   task automatic do_clear();
      soft_clr = 1'b1;
      step();
      soft_clr = 1'b0;
      clear_log();
   endtask

   // Present each lane's next sample every cycle until all streams have
   // been accepted, then idle for 'drain' cycles. lane_ready is logged once
   // per handshake cycle.
   task automatic run_streams(input int drain);
      int   ptr [LANES];
      int   guard;
      bit   all_done;
      logic [LANES-1:0] xfer;
      ready_log.delete();
      for (int i = 0; i < LANES; i++) ptr[i] = 0;
      guard    = 0;
      all_done = 1'b1;
      for (int i = 0; i < LANES; i++) if (len_a[i] > 0) all_done = 1'b0;
      while (!all_done && guard < 200) begin
         for (int i = 0; i < LANES; i++) begin
            lane_valid[i] = (ptr[i] < len_a[i]);
            lane_data[i]  = (ptr[i] < len_a[i]) ? seq_a[i][ptr[i]] : 1'b0;
         end
         #1;
         ready_log.push_back(int'(lane_ready));
         xfer = lane_valid & lane_ready;
         step();
         for (int i = 0; i < LANES; i++) begin
            if (xfer[i]) begin
               ptr[i]++;
               last_xfer_cyc[i] = cyc;
            end
         end
         guard++;
         all_done = 1'b1;
         for (int i = 0; i < LANES; i++) if (ptr[i] < len_a[i]) all_done = 1'b0;
      end
      lane_valid = '0;
      lane_data  = '0;
      check("stream_done", int'(all_done), 1);
      repeat (drain) step();
   endtask

   initial begin
      rst        = 1'b0;
      en         = 1'b1;
      soft_clr   = 1'b0;
      lane_valid = '0;
      lane_data  = '0;
      cnt_sel    = '0;
      for (int i = 0; i < LANES; i++) last_xfer_cyc[i] = 0;
      clear_seq();

      // ---- reset state ----
      #1;
      check("rst_det_valid", int'(det_valid), 0);
      check("rst_det_lane", int'(det_lane), 0);
      check("rst_cnt0", int'(cnt_val), 0);
      @(posedge clk);
      #3 rst = 1'b1;
      step();
      check("rst_ready", int'(lane_ready), 4'hF);

      // ---- single lane, basic detection: lane 0 sends 0,1,1,1,0 ----
      clear_log();
      clear_seq();
      seq_a[0] = 32'h0000_000E; len_a[0] = 5;
      run_streams(6);
      check("t1_det_count", det_lane_q.size(), 1);
      check("t1_det_lane", q_lane(0), 0);
      // Fifth sample transfers at edge E. It is granted in the next cycle,
      // so det_valid is registered at edge E+1. That is two cycles after the
      // cycle in which the sample was presented.
      check("t1_det_latency", q_cyc(0) - last_xfer_cyc[0], 1);
      read_cnt("t1_cnt0", 0, 1);

      // ---- overlap: lane 2 sends 0,1,1,1,0,1,1,1,0 ----
      clear_log();
      clear_seq();
      seq_a[2] = 32'h0000_00EE; len_a[2] = 9;
      run_streams(6);
      check("t2_det_count", det_lane_q.size(), 2);
      check("t2_det_lane0", q_lane(0), 2);
      check("t2_det_lane1", q_lane(1), 2);
      check("t2_det_spacing", q_cyc(1) - q_cyc(0), 4);
      read_cnt("t2_cnt2", 2, 2);

      // ---- fairness: all lanes stream 0,1,1,1,0 at once ----
      do_clear();
      clear_seq();
      for (int i = 0; i < LANES; i++) begin
         seq_a[i] = 32'h0000_000E;
         len_a[i] = 5;
      end
      run_streams(8);
      // Cycle 0: all buffers are empty. After that, only the granted lane is
      // ready, rotating 0,1,2,3.
      check("t3_ready_c0", log_at(0), 4'hF);
      for (int c = 1; c <= 16; c++) begin
         check($sformatf("t3_ready_c%0d", c), log_at(c), 1 << ((c - 1) % 4));
      end
      check("t3_det_count", det_lane_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t3_det_lane%0d", k), q_lane(k), k);
      end
      for (int k = 1; k < 4; k++) begin
         check($sformatf("t3_det_gap%0d", k), q_cyc(k) - q_cyc(k - 1), 1);
      end
      for (int k = 0; k < 4; k++) begin
         read_cnt($sformatf("t3_cnt%0d", k), k, 1);
      end

      // ---- interleaving isolation: lane 1 0,1,1 / lane 3 1,1; lane 1 1,0 ----
      do_clear();
      clear_seq();
      seq_a[1] = 32'h0000_0006; len_a[1] = 3;
      seq_a[3] = 32'h0000_0003; len_a[3] = 2;
      run_streams(4);
      clear_seq();
      seq_a[1] = 32'h0000_0001; len_a[1] = 2;
      run_streams(4);
      check("t4_det_count", det_lane_q.size(), 1);
      check("t4_det_lane", q_lane(0), 1);
      read_cnt("t4_cnt1", 1, 1);
      read_cnt("t4_cnt3", 3, 0);
      // Lane 3 went IDLE->IDLE. Sending 1,0 now must not complete a pattern.
      clear_seq();
      seq_a[3] = 32'h0000_0001; len_a[3] = 2;
      run_streams(4);
      check("t4_lane3_idle", det_lane_q.size(), 1);

      // ---- saturation and soft clear: lane 0 completes 5 patterns ----
      do_clear();
      clear_seq();
      seq_a[0] = 32'h0;
      for (int p = 0; p < 5; p++) begin
         seq_a[0][4*p+1] = 1'b1;
         seq_a[0][4*p+2] = 1'b1;
         seq_a[0][4*p+3] = 1'b1;
      end
      len_a[0] = 21;
      run_streams(6);
      check("t5_det_count", det_lane_q.size(), 5);
      read_cnt("t5_cnt_sat", 0, 3);
      // Offer a Bike during the clear. It must not be accepted.
      lane_valid = 4'b0001;
      lane_data  = 4'b0000;
      soft_clr   = 1'b1;
      #1;
      check("t5_ready_in_clr", int'(lane_ready), 0);
      step();
      soft_clr   = 1'b0;
      lane_valid = '0;
      read_cnt("t5_cnt_cleared", 0, 0);
      check("t5_det_valid_cleared", int'(det_valid), 0);
      clear_log();
      clear_seq();
      seq_a[0] = 32'h0000_0007; len_a[0] = 4;   // 1,1,1,0
      run_streams(5);
      check("t5_no_det_after_clr", det_lane_q.size(), 0);

      // ---- asynchronous reset mid-pattern ----
      do_clear();
      clear_seq();
      seq_a[3] = 32'h0000_000E; len_a[3] = 5;   // completes on lane 3
      seq_a[0] = 32'h0000_000E; len_a[0] = 4;   // lane 0 left in BCCC
      run_streams(8);
      check("t6_pre_det_count", det_lane_q.size(), 1);
      check("t6_pre_det_lane", int'(det_lane), 3);
      read_cnt("t6_pre_cnt3", 3, 1);
      #2 rst = 1'b0;                             // between clock edges
      #1;
      check("t6_rst_det_lane", int'(det_lane), 0);
      check("t6_rst_det_valid", int'(det_valid), 0);
      check("t6_rst_cnt3", int'(cnt_val), 0);
      check("t6_rst_ready", int'(lane_ready), 4'hF);
      #2 rst = 1'b1;
      step();
      clear_log();
      clear_seq();
      seq_a[0] = 32'h0; len_a[0] = 1;            // closing Bike after reset
      run_streams(4);
      check("t6_no_det_after_rst", det_lane_q.size(), 0);

      // ---- enable low with a full buffer ----
      clear_log();
      clear_seq();
      seq_a[1] = 32'h0000_000E; len_a[1] = 4;   // lane 1 to BCCC
      run_streams(3);
      en = 1'b0;
      clear_seq();
      seq_a[1] = 32'h0; len_a[1] = 1;           // closing Bike, parked
      run_streams(3);
      check("t7_ready_en0", int'(lane_ready), 4'b1101);
      check("t7_no_det_en0", det_lane_q.size(), 0);
      read_cnt("t7_cnt1_frozen", 1, 0);
      en = 1'b1;
      repeat (3) step();
      check("t7_det_after_en", det_lane_q.size(), 1);
      check("t7_det_lane", q_lane(0), 1);
      read_cnt("t7_cnt1", 1, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
